// File: rtl/npu_pkg.sv
// Shared definitions for the NPU pixel pipeline: coordinate width, FSM encoding
// and window bit-offset helper.
package npu_pkg;

  localparam int unsigned COORD_W = 16;

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  typedef enum logic {
    StIdle = IDLE,
    StRun  = RUN
  } state_e;

  // Bit offset of window element (r,c) for a k-by-k window of dw-bit pixels.
  function automatic int unsigned win_off(int unsigned r, int unsigned c, int unsigned k,
                                          int unsigned dw);
    return (r * k + c) * dw;
  endfunction

endpackage

// File: rtl/line_ram.sv
// One line buffer: asynchronous read, synchronous write, so a read and a write
// at the same address in one cycle return the old contents.
module line_ram #(
  parameter int unsigned LINE_W = 64,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = (LINE_W > 1) ? $clog2(LINE_W) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [LINE_W];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_stream_gen.sv
// Sliding K x K window generator over a raster pixel stream with frame-start
// alignment, centre pixel/coordinates and border (win_full) flag.
module window_stream_gen
  import npu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned K      = 7,
  parameter int unsigned LINE_W = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_enable,
  input  logic                  frame_start,
  input  logic [DATA_W-1:0]     data_in,
  output logic                  win_valid,
  output logic [K*K*DATA_W-1:0] window,
  output logic [DATA_W-1:0]     center_pixel,
  output logic                  win_full,
  output logic [COORD_W-1:0]    center_col,
  output logic [COORD_W-1:0]    center_row
);

  localparam int unsigned AW      = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int unsigned MID     = (K - 1) / 2;
  localparam int unsigned CTR_OFF = win_off(MID, MID, K, DATA_W);

  localparam logic [COORD_W-1:0] KM1      = COORD_W'(K - 1);
  localparam logic [COORD_W-1:0] HALF     = COORD_W'(MID);
  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(LINE_W - 1);

  state_e                  state_q, state_d;
  logic [COORD_W-1:0]      col_q, col_d, row_q, row_d;
  logic [COORD_W-1:0]      cur_col, cur_row;
  logic                    accept, full;
  logic [K*K*DATA_W-1:0]   window_q, window_d;
  logic [DATA_W-1:0]       lb_rd [K-1];
  logic [DATA_W-1:0]       col_vec [K];

  logic                    win_valid_q, win_full_q;
  logic [COORD_W-1:0]      center_col_q, center_row_q;

  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    logic [DATA_W-1:0] wd;
    if (i == 0) begin : g_first
      assign wd = data_in;
    end else begin : g_chain
      assign wd = lb_rd[i-1];
    end
    line_ram #(
      .LINE_W (LINE_W),
      .DATA_W (DATA_W),
      .AW     (AW)
    ) u_ram (
      .clk   (clk),
      .we    (accept),
      .addr  (cur_col[AW-1:0]),
      .wdata (wd),
      .rdata (lb_rd[i])
    );
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    window_d = window_q;

    accept  = data_enable && (frame_start || (state_q == StRun));
    // A frame_start pixel is (0,0) regardless of where the counters were.
    cur_col = frame_start ? '0 : col_q;
    cur_row = frame_start ? '0 : row_q;
    full    = (cur_row >= KM1) && (cur_col >= KM1);

    // Oldest line on top; the incoming pixel forms the bottom row.
    for (int r = 0; r < int'(K) - 1; r++) begin
      col_vec[r] = lb_rd[int'(K) - 2 - r];
    end
    col_vec[K-1] = data_in;

    if (accept) begin
      state_d = StRun;
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == '1) ? cur_row : cur_row + COORD_W'(1);
      end else begin
        col_d = cur_col + COORD_W'(1);
        row_d = cur_row;
      end
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K - 1; c++) begin
          window_d[win_off(r, c, K, DATA_W) +: DATA_W] =
              window_q[win_off(r, c + 1, K, DATA_W) +: DATA_W];
        end
        window_d[win_off(r, K - 1, K, DATA_W) +: DATA_W] = col_vec[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      window_q     <= '0;
      win_valid_q  <= 1'b0;
      win_full_q   <= 1'b0;
      center_col_q <= '0;
      center_row_q <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      window_q    <= window_d;
      win_valid_q <= accept;
      if (accept) begin
        win_full_q   <= full;
        center_col_q <= full ? cur_col - HALF : '0;
        center_row_q <= full ? cur_row - HALF : '0;
      end
    end
  end

  assign win_valid    = win_valid_q;
  assign window       = window_q;
  assign center_pixel = window_q[CTR_OFF +: DATA_W];
  assign win_full     = win_full_q;
  assign center_col   = center_col_q;
  assign center_row   = center_row_q;

endmodule
